// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares one single-ported unified instruction/data memory between the
//    fetch stage (i_*) and the load/store stage (d_*). One access is granted
//    at a time. Each access drives a one-cycle mem_en strobe, counts out the
//    fixed memory latency, and then returns read data with a one-cycle ready
//    pulse to the side that was granted. Simultaneous requests alternate
//    between the two sides. The first tie after reset goes to the data side.
//
// Ports
//    CLK, RST             clock (rising edge), synchronous active-high reset
//    i_req/i_addr         fetch request, held until i_ready
//    i_rdata/i_ready      fetched word and completion pulse
//    d_req/d_we/d_addr    data request (d_we=1 store), held until d_ready
//    d_wdata              store data
//    d_rdata/d_ready      load data and completion pulse
//    stall                pipeline freeze while any request is unserved
//    mem_en/mem_we        memory strobe (one cycle per access) and write enable
//    mem_addr/mem_wdata   registered at grant, held until the next grant
//    mem_rdata            memory read data, valid MEM_LAT cycles after mem_en
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no access in flight, arbitrate this cycle
// ISSUE_I | fetch access strobe (mem_en) cycle
// ISSUE_D | data access strobe (mem_en) cycle
// WAIT_I  | fetch latency countdown
// WAIT_D  | data latency countdown
// DONE_I  | fetch read data valid, i_ready pulse
// DONE_D  | data read data valid, d_ready pulse

module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_I,
      ISSUE_D,
      WAIT_I,
      WAIT_D,
      DONE_I,
      DONE_D
   } state_t;

   state_t            state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              last_d_q, last_d_nxt;   // 1 = last tie went to data side
   logic              grant_d;
   logic              mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_d_q  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         last_d_q  <= last_d_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      cnt_nxt       = cnt_q;
      last_d_nxt    = last_d_q;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      grant_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               // Data wins when alone, or on a tie when fetch won the last tie.
               grant_d = d_req && (!i_req || !last_d_q);
               if (i_req && d_req) begin
                  last_d_nxt = grant_d;
               end
               if (grant_d) begin
                  mem_addr_nxt  = d_addr;
                  mem_we_nxt    = d_we;
                  mem_wdata_nxt = d_wdata;
                  state_nxt     = ISSUE_D;
               end else begin
                  mem_addr_nxt  = i_addr;
                  mem_we_nxt    = 1'b0;
                  state_nxt     = ISSUE_I;
               end
            end
         end

         ISSUE_I: begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = (MEM_LAT == 1) ? DONE_I : WAIT_I;
         end

         ISSUE_D: begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = (MEM_LAT == 1) ? DONE_D : WAIT_D;
         end

         WAIT_I: begin
            if (cnt_q <= CNT_ONE) begin
               state_nxt = DONE_I;
            end else begin
               cnt_nxt = cnt_q - CNT_ONE;
            end
         end

         WAIT_D: begin
            if (cnt_q <= CNT_ONE) begin
               state_nxt = DONE_D;
            end else begin
               cnt_nxt = cnt_q - CNT_ONE;
            end
         end

         DONE_I:  state_nxt = IDLE;
         DONE_D:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_en  = (state_q == ISSUE_I) || (state_q == ISSUE_D);
   assign i_ready = (state_q == DONE_I);
   assign d_ready = (state_q == DONE_D);

   assign i_rdata = i_ready ? mem_rdata : '0;
   assign d_rdata = d_ready ? mem_rdata : '0;

   // Drops in the ready cycle so the pipeline advances exactly on completion;
   // a dropped request (flush) releases the stall immediately.
   assign stall = (i_req && !i_ready) || (d_req && !d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MEM_LAT = 2;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              i_req = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              stall;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
      .CLK(CLK), .RST(RST),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory model: data appears exactly MEM_LAT cycles after the mem_en cycle,
   // garbage otherwise, so a ready pulse at the wrong time returns wrong data.
   function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
      if (a == 32'h40) return 32'h2402000A;
      return {a[15:0], ~a[15:0]};
   endfunction

   logic [ADDR_W-1:0] lat_addr = '0;
   int                lat_cnt = 0;
   always @(posedge CLK) begin
      if (mem_en) begin
         lat_addr <= mem_addr;
         lat_cnt  <= MEM_LAT;
      end else if (lat_cnt > 0) begin
         lat_cnt <= lat_cnt - 1;
      end
   end
   assign mem_rdata = (lat_cnt == 1) ? data_of(lat_addr) : 32'hBAD0BAD0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
      bit                chk_wd;
      int                cyc;
   } mem_exp_t;

   typedef struct {
      bit                is_d;
      logic [DATA_W-1:0] data;
      bit                chk_data;
      int                cyc;
   } rdy_exp_t;

   mem_exp_t mq[$];
   rdy_exp_t rq[$];

   task automatic push_mem(input logic [ADDR_W-1:0] a, input logic we,
                           input logic [DATA_W-1:0] wd, input bit cw, input int c);
      mem_exp_t e;
      e.addr = a; e.we = we; e.wdata = wd; e.chk_wd = cw; e.cyc = c;
      mq.push_back(e);
   endtask

   task automatic push_rdy(input bit is_d, input logic [DATA_W-1:0] data,
                           input bit cd, input int c);
      rdy_exp_t e;
      e.is_d = is_d; e.data = data; e.chk_data = cd; e.cyc = c;
      rq.push_back(e);
   endtask

   task automatic take_rdy(input bit is_d, input logic [DATA_W-1:0] data);
      rdy_exp_t e;
      if (rq.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL rdy_unexpected: got ready side %0d, none expected (cycle %0d)", is_d, cyc);
      end else begin
         e = rq.pop_front();
         chk("rdy_side", is_d, e.is_d);
         chk("rdy_cycle", cyc, e.cyc);
         if (e.chk_data) chk("rdy_data", data, e.data);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents mem_en or a ready.
   always @(negedge CLK) begin
      mem_exp_t m;
      if (mem_en) begin
         if (mq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL mem_en_unexpected: got mem_en=1 addr %0h, none expected (cycle %0d)",
                     mem_addr, cyc);
         end else begin
            m = mq.pop_front();
            chk("mem_cycle", cyc, m.cyc);
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_we", mem_we, m.we);
            if (m.chk_wd) chk("mem_wdata", mem_wdata, m.wdata);
         end
      end
      if (i_ready) take_rdy(1'b0, i_rdata);
      else         chk("i_rdata_idle", i_rdata, 0);
      if (d_ready) take_rdy(1'b1, d_rdata);
      else         chk("d_rdata_idle", d_rdata, 0);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic steps(input int n, input logic exp_stall, input string nm);
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         chk(nm, stall, exp_stall);
         tick();
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   int g;

   initial begin
      tick();
      do_reset();

      // reset state
      @(negedge CLK);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_stall", stall, 0);
      tick();

      // fetch alone; address changes after grant must be ignored
      g = cyc;
      i_req = 1'b1; i_addr = 32'h40;
      push_mem(32'h40, 1'b0, '0, 1'b0, g + 1);
      push_rdy(1'b0, 32'h2402000A, 1'b1, g + 3);
      steps(1, 1'b1, "s1_stall");
      i_addr = 32'h99;
      steps(2, 1'b1, "s1_stall");
      steps(1, 1'b0, "s1_stall_ready");
      i_req = 1'b0; i_addr = '0;
      steps(1, 1'b0, "s1_stall_idle");

      // first tie after reset goes to D
      do_reset();
      g = cyc;
      i_req = 1'b1; i_addr = 32'h44;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
      push_mem(32'h1000, 1'b0, '0, 1'b0, g + 1);
      push_rdy(1'b1, data_of(32'h1000), 1'b1, g + 3);
      push_mem(32'h44, 1'b0, '0, 1'b0, g + 5);
      push_rdy(1'b0, data_of(32'h44), 1'b1, g + 7);
      steps(4, 1'b1, "s2_stall");
      d_req = 1'b0;
      steps(3, 1'b1, "s2_stall_i");
      steps(1, 1'b0, "s2_stall_ready");
      i_req = 1'b0;
      steps(1, 1'b0, "s2_stall_idle");

      // repeated ties alternate D, I, D, I, then D alone
      do_reset();
      g = cyc;
      i_req = 1'b1; i_addr = 32'h44;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
      push_mem(32'h1000, 1'b0, '0, 1'b0, g + 1);
      push_rdy(1'b1, data_of(32'h1000), 1'b1, g + 3);
      push_mem(32'h44, 1'b0, '0, 1'b0, g + 5);
      push_rdy(1'b0, data_of(32'h44), 1'b1, g + 7);
      push_mem(32'h2000, 1'b0, '0, 1'b0, g + 9);
      push_rdy(1'b1, data_of(32'h2000), 1'b1, g + 11);
      push_mem(32'h48, 1'b0, '0, 1'b0, g + 13);
      push_rdy(1'b0, data_of(32'h48), 1'b1, g + 15);
      push_mem(32'h2004, 1'b0, '0, 1'b0, g + 17);
      push_rdy(1'b1, data_of(32'h2004), 1'b1, g + 19);
      steps(4, 1'b1, "s3_stall");
      d_addr = 32'h2000;
      steps(4, 1'b1, "s3_stall");
      i_addr = 32'h48;
      steps(4, 1'b1, "s3_stall");
      d_addr = 32'h2004;
      steps(4, 1'b1, "s3_stall");
      i_req = 1'b0;
      steps(3, 1'b1, "s3_stall");
      steps(1, 1'b0, "s3_stall_ready");
      d_req = 1'b0;
      steps(1, 1'b0, "s3_stall_idle");

      // store
      g = cyc;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1004; d_wdata = 32'hDEADBEEF;
      push_mem(32'h1004, 1'b1, 32'hDEADBEEF, 1'b1, g + 1);
      push_rdy(1'b1, '0, 1'b0, g + 3);
      steps(3, 1'b1, "s4_stall");
      steps(1, 1'b0, "s4_stall_ready");
      d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
      steps(1, 1'b0, "s4_stall_idle");

      // reset during WAIT_D aborts the access without a ready pulse
      g = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1008;
      push_mem(32'h1008, 1'b0, '0, 1'b0, g + 1);
      steps(2, 1'b1, "s5_stall");
      RST = 1'b1;
      steps(1, 1'b1, "s5_stall_rst");
      RST = 1'b0; d_req = 1'b0;
      @(negedge CLK);
      chk("s5_mem_en", mem_en, 0);
      chk("s5_d_ready", d_ready, 0);
      chk("s5_mem_addr", mem_addr, 0);
      chk("s5_mem_we", mem_we, 0);
      tick();
      steps(2, 1'b0, "s5_stall_idle");
      g = cyc;
      d_req = 1'b1; d_addr = 32'h100C;
      push_mem(32'h100C, 1'b0, '0, 1'b0, g + 1);
      push_rdy(1'b1, data_of(32'h100C), 1'b1, g + 3);
      steps(3, 1'b1, "s5_stall_new");
      steps(1, 1'b0, "s5_stall_ready");
      d_req = 1'b0;
      steps(1, 1'b0, "s5_stall_idle2");

      // flush: fetch dropped mid-access, d_req arrives in the DONE cycle
      g = cyc;
      i_req = 1'b1; i_addr = 32'h50;
      push_mem(32'h50, 1'b0, '0, 1'b0, g + 1);
      push_rdy(1'b0, data_of(32'h50), 1'b1, g + 3);
      steps(2, 1'b1, "s6_stall");
      i_req = 1'b0;
      steps(1, 1'b0, "s6_stall_flush");
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1010;
      push_mem(32'h1010, 1'b0, '0, 1'b0, g + 5);
      push_rdy(1'b1, data_of(32'h1010), 1'b1, g + 7);
      steps(4, 1'b1, "s6_stall_d");
      steps(1, 1'b0, "s6_stall_ready");
      d_req = 1'b0;
      steps(3, 1'b0, "s6_stall_idle");

      chk("mem_queue_empty", mq.size(), 0);
      chk("rdy_queue_empty", rq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
